map_frame_buffer: RTL and testbench
===================================

Name: map_frame_buffer

Overview:
- Double-buffered store for the 16x8 tile map, with 2 bits per tile.
- Directly upstream of the tile-address mapper: it drives the 256-bit `map` bus that the mapper indexes.
- Tile updates arrive from the command decoder and are written into a shadow buffer.
- A commit copies the shadow buffer to the displayed map, but only at a frame boundary, so a redraw never tears mid-frame.

Parameters:
- TILE_BITS, 2, bits per tile code.
- NUM_TILES, 128, tiles per map (16 columns x 8 rows).
- CLEAR_WORD, 32, shadow bits zeroed per cycle during CLEAR (16 tiles = one map row).

Ports:
- clk  in  1  system clock (MTL pixel-domain clock).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_op  in  2  0=WRITE, 1=COMMIT, 2=CLEAR, 3=NOP.
- cmd_index  in  7  tile index = xtile + 16*ytile (WRITE only).
- cmd_tile  in  2  tile code (WRITE only).
- frame_start  in  1  one-cycle pulse at first line of vertical blank, from the MTL controller.
- map  out  256  displayed map; tile i occupies bits [2i+1:2i].
- pending  out  1  a commit is waiting for frame_start.
- swap_done  out  1  one-cycle pulse on the cycle `map` takes the new value.
- frame_count  out  8  wrapping count of frame_start pulses (debug).

Behaviour:
- Reset (async, any state) sets:
  - shadow = 0, map = 0, state = IDLE;
  - pending = 0, swap_done = 0, frame_count = 0;
  - clear counter = 0.
- States: IDLE, CLEAR, PENDING.
- cmd_ready = 1 only in IDLE (combinational from state).
- IDLE handling of an accepted command:
  - WRITE: shadow[2i+1:2i] <= cmd_tile on the next edge; stay in IDLE.
  - COMMIT: go to PENDING; pending = 1 from the next cycle.
  - CLEAR: go to CLEAR; counter = 0.
  - NOP: no effect.
- CLEAR:
  - Each cycle zeroes shadow bits [32k+31:32k] for k = counter, then increments the counter.
  - After k=7 has been zeroed (8 cycles), return to IDLE.
  - `map` is untouched.
- PENDING, on frame_start = 1:
  - map <= shadow on the edge; swap_done = 1 for the following cycle only.
  - pending <= 0; state <= IDLE.
- Latency:
  - The earliest swap uses the first frame_start sampled strictly after the cycle the COMMIT was accepted.
  - If frame_start is high in the same cycle as COMMIT acceptance, that pulse is ignored and the swap waits for the next frame.
- Back-pressure: commands are back-pressured (cmd_ready = 0) during CLEAR and PENDING; nothing is dropped.
- frame_count increments on every frame_start, in all states, wrapping 255 -> 0.
- `map` changes only on a swap edge or on reset; it never changes mid-frame.
- cmd_index is 7 bits and NUM_TILES = 128, so no index is out of range.
- Reset during CLEAR or PENDING aborts the operation; both buffers read 0 afterwards.
- All outputs are registered except cmd_ready.

Decomposition:
- Shared package map_pkg holds:
  - constants MAP_COLS=16, MAP_ROWS=8, TILE_BITS, MAP_W=256;
  - enum cmd_op_t {CMD_WRITE, CMD_COMMIT, CMD_CLEAR, CMD_NOP};
  - enum fb_state_t {FB_IDLE, FB_CLEAR, FB_PENDING}.
- The package is shared with the tile-address mapper and the command decoder.
- No sub-module required; the shadow write and clear logic stay inline.

Test Plan:
1. Reset check:
   - Release reset.
   - Expect map=0, pending=0, cmd_ready=1, frame_count=0.
2. Write, commit, swap:
   - WRITE idx 17 tile 2, WRITE idx 127 tile 3, then COMMIT.
   - Expect map unchanged and pending=1 until frame_start.
   - The cycle after frame_start: map[35:34]=2, map[255:254]=3, swap_done=1 for 1 cycle, pending=0.
3. COMMIT coincident with frame_start:
   - Expect no swap on that pulse; swap on the next frame_start; frame_count +2.
4. Back-pressure in PENDING:
   - Hold cmd_valid with WRITE idx 0 tile 1 while in PENDING.
   - Expect cmd_ready=0 and shadow unchanged.
   - After the swap, the write is accepted, and map[1:0] stays at its old value until the next commit.
5. CLEAR sequence:
   - Fill shadow with all 3s via 128 WRITEs, COMMIT, wait for the swap, then CLEAR.
   - Expect cmd_ready=0 for exactly 8 cycles and map still all 1s.
   - COMMIT plus frame_start then gives map=0.
6. Reset mid-PENDING and frame_count wrap:
   - Assert reset while pending=1: expect map=0, state IDLE immediately (async).
   - Apply 256 frame_start pulses: expect frame_count to wrap to 0.

Source files
------------

// File: rtl/map_pkg.sv
// Shared constants and types for the tile map path: frame buffer, mapper, decoder.
package map_pkg;

    localparam int unsigned MAP_COLS    = 16;
    localparam int unsigned MAP_ROWS    = 8;
    localparam int unsigned TILE_BITS   = 2;
    localparam int unsigned NUM_TILES   = MAP_COLS * MAP_ROWS;
    localparam int unsigned MAP_W       = NUM_TILES * TILE_BITS;
    localparam int unsigned CLEAR_WORD  = 32;
    localparam int unsigned CLEAR_STEPS = MAP_W / CLEAR_WORD;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'd0,
        CMD_COMMIT = 2'd1,
        CMD_CLEAR  = 2'd2,
        CMD_NOP    = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        FB_IDLE    = 2'd0,
        FB_CLEAR   = 2'd1,
        FB_PENDING = 2'd2
    } fb_state_t;

endpackage

// File: rtl/map_frame_buffer_if.sv
// Command channel from the command decoder into the map frame buffer.
interface map_frame_buffer_if;
    import map_pkg::*;

    logic    cmd_valid;
    logic    cmd_ready;
    cmd_op_t cmd_op;
    logic [6:0] cmd_index;
    logic [TILE_BITS-1:0] cmd_tile;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_index,
        output cmd_tile,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_index,
        input  cmd_tile,
        output cmd_ready
    );

endinterface

// File: rtl/map_frame_buffer.sv
// Double-buffered 16x8 tile map: writes land in a shadow copy, which is
// copied to the displayed map only on a frame_start so the display never tears.
module map_frame_buffer
    import map_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    map_frame_buffer_if.slave   cmd,
    input  logic                frame_start,
    output logic [MAP_W-1:0]    map,
    output logic                pending,
    output logic                swap_done,
    output logic [7:0]          frame_count
);

    fb_state_t          state_q, state_d;
    logic [MAP_W-1:0]   shadow_q, shadow_d;
    logic [MAP_W-1:0]   map_q, map_d;
    logic               pending_q, pending_d;
    logic               swap_done_q, swap_done_d;
    logic [7:0]         frame_count_q, frame_count_d;
    logic [2:0]         clr_cnt_q, clr_cnt_d;

    // Commands are only taken while idle; CLEAR and PENDING back-pressure.
    assign cmd.cmd_ready = (state_q == FB_IDLE);

    // Next-state: command handling, row-wise clear, and frame-aligned swap.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        map_d         = map_q;
        pending_d     = pending_q;
        swap_done_d   = 1'b0;
        clr_cnt_d     = clr_cnt_q;
        frame_count_d = frame_count_q + {7'd0, frame_start};

        unique case (state_q)
            FB_IDLE: begin
                if (cmd.cmd_valid) begin
                    unique case (cmd.cmd_op)
                        CMD_WRITE: shadow_d[{cmd.cmd_index, 1'b0} +: TILE_BITS] = cmd.cmd_tile;
                        CMD_COMMIT: begin
                            // A frame_start seen now is ignored: the swap waits for the next one.
                            state_d   = FB_PENDING;
                            pending_d = 1'b1;
                        end
                        CMD_CLEAR: begin
                            state_d   = FB_CLEAR;
                            clr_cnt_d = 3'd0;
                        end
                        CMD_NOP: ;
                    endcase
                end
            end
            FB_CLEAR: begin
                // One map row (32 bits) per cycle.
                shadow_d[{clr_cnt_q, 5'd0} +: CLEAR_WORD] = '0;
                clr_cnt_d = clr_cnt_q + 3'd1;
                if (clr_cnt_q == 3'(CLEAR_STEPS - 1)) begin
                    state_d = FB_IDLE;
                end
            end
            FB_PENDING: begin
                if (frame_start) begin
                    map_d       = shadow_q;
                    swap_done_d = 1'b1;
                    pending_d   = 1'b0;
                    state_d     = FB_IDLE;
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FB_IDLE;
            shadow_q      <= '0;
            map_q         <= '0;
            pending_q     <= 1'b0;
            swap_done_q   <= 1'b0;
            frame_count_q <= 8'd0;
            clr_cnt_q     <= 3'd0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            map_q         <= map_d;
            pending_q     <= pending_d;
            swap_done_q   <= swap_done_d;
            frame_count_q <= frame_count_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

    assign map         = map_q;
    assign pending     = pending_q;
    assign swap_done   = swap_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_map_frame_buffer.sv
// Self-checking bench for map_frame_buffer against a tile-array reference model.
module tb_map_frame_buffer;
    import map_pkg::*;

    logic             clk;
    logic             reset;
    logic             frame_start;
    logic [MAP_W-1:0] map;
    logic             pending;
    logic             swap_done;
    logic [7:0]       frame_count;

    map_frame_buffer_if cmd_if ();

    map_frame_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if.slave),
        .frame_start (frame_start),
        .map         (map),
        .pending     (pending),
        .swap_done   (swap_done),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: tiles as arrays, busy conditions as plain counters/flags.
    logic [1:0] m_shadow [NUM_TILES];
    logic [1:0] m_disp   [NUM_TILES];
    bit         m_pending;
    int         m_clear_left;
    bit         m_swap;
    int         m_frames;

    task automatic check_val(input string tag, input logic [MAP_W-1:0] got,
                             input logic [MAP_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MAP_W-1:0] pack_disp();
        logic [MAP_W-1:0] v = '0;
        for (int i = 0; i < NUM_TILES; i++) v[2*i +: 2] = m_disp[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_TILES; i++) begin
            m_shadow[i] = 2'd0;
            m_disp[i]   = 2'd0;
        end
        m_pending    = 0;
        m_clear_left = 0;
        m_swap       = 0;
        m_frames     = 0;
    endtask

    function automatic bit model_ready();
        return !m_pending && (m_clear_left == 0);
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".map"}, map, pack_disp());
        check_val({tag, ".pending"}, MAP_W'(pending), MAP_W'(m_pending));
        check_val({tag, ".swap_done"}, MAP_W'(swap_done), MAP_W'(m_swap));
        check_val({tag, ".frame_count"}, MAP_W'(frame_count), MAP_W'(m_frames));
    endtask

    // One clock: drive at negedge, check ready, clock the DUT and the model, check outputs.
    task automatic step(input bit v, input logic [1:0] op, input logic [6:0] idx,
                        input logic [1:0] tile, input bit fs, output bit rdy_seen);
        bit rdy_exp;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = cmd_op_t'(op);
        cmd_if.cmd_index = idx;
        cmd_if.cmd_tile  = tile;
        frame_start      = fs;
        #1;
        rdy_exp  = model_ready();
        rdy_seen = cmd_if.cmd_ready;
        check_val("cmd_ready", MAP_W'(cmd_if.cmd_ready), MAP_W'(rdy_exp));
        @(posedge clk);
        m_swap = 0;
        if (fs) m_frames = (m_frames + 1) % 256;
        if (m_pending) begin
            if (fs) begin
                for (int i = 0; i < NUM_TILES; i++) m_disp[i] = m_shadow[i];
                m_pending = 0;
                m_swap    = 1;
            end
        end else if (m_clear_left > 0) begin
            int row = CLEAR_STEPS - m_clear_left;
            for (int c = 0; c < MAP_COLS; c++) m_shadow[row*MAP_COLS + c] = 2'd0;
            m_clear_left--;
        end else if (v) begin
            case (op)
                2'd0: m_shadow[idx] = tile;
                2'd1: m_pending = 1;
                2'd2: m_clear_left = CLEAR_STEPS;
                default: ;
            endcase
        end
        @(negedge clk);
        check_outputs("step");
    endtask

    task automatic idle(input int n, input bit fs);
        bit r;
        for (int i = 0; i < n; i++) step(0, 2'd3, 7'd0, 2'd0, fs, r);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_val("rst.map", map, '0);
        check_val("rst.pending", MAP_W'(pending), '0);
        check_val("rst.ready", MAP_W'(cmd_if.cmd_ready), MAP_W'(1));
        check_val("rst.frame_count", MAP_W'(frame_count), '0);
        @(negedge clk);
        reset = 1'b0;
        check_outputs("rst");
    endtask

    initial begin
        bit r;
        int low_cnt;
        reset            = 1'b0;
        frame_start      = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = CMD_NOP;
        cmd_if.cmd_index = 7'd0;
        cmd_if.cmd_tile  = 2'd0;
        @(negedge clk);
        do_reset();

        // Write, commit, swap on the following frame_start.
        step(1, 2'd0, 7'd17, 2'd2, 0, r);
        step(1, 2'd0, 7'd127, 2'd3, 0, r);
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        idle(3, 0);
        idle(1, 1);
        check_val("swap.tile17", MAP_W'(map[35:34]), MAP_W'(2));
        check_val("swap.tile127", MAP_W'(map[255:254]), MAP_W'(3));
        check_val("swap.pulse", MAP_W'(swap_done), MAP_W'(1));
        idle(1, 0);
        check_val("swap.pulse_end", MAP_W'(swap_done), '0);

        // COMMIT together with frame_start: that pulse must not swap.
        step(1, 2'd0, 7'd5, 2'd1, 0, r);
        step(1, 2'd1, 7'd0, 2'd0, 1, r);
        check_val("coinc.no_swap", MAP_W'(swap_done), '0);
        idle(2, 0);
        idle(1, 1);
        check_val("coinc.swap", MAP_W'(swap_done), MAP_W'(1));

        // Back-pressure: a WRITE held during PENDING waits for the swap.
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        for (int i = 0; i < 4; i++) step(1, 2'd0, 7'd0, 2'd1, 0, r);
        step(1, 2'd0, 7'd0, 2'd1, 1, r);
        step(1, 2'd0, 7'd0, 2'd1, 0, r);
        check_val("bp.accepted", MAP_W'(r), MAP_W'(1));
        idle(2, 0);
        check_val("bp.map_old", MAP_W'(map[1:0]), '0);

        // Fill with 3s, swap, then CLEAR the shadow.
        for (int i = 0; i < NUM_TILES; i++) step(1, 2'd0, 7'(i), 2'd3, 0, r);
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        idle(1, 1);
        step(1, 2'd2, 7'd0, 2'd0, 0, r);
        low_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 2'd3, 7'd0, 2'd0, 0, r);
            if (!r) low_cnt++;
        end
        check_val("clear.busy_cycles", MAP_W'(low_cnt), MAP_W'(8));
        check_val("clear.map_kept", map, '1);
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        idle(1, 1);
        check_val("clear.map_zero", map, '0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 7'($urandom),
                 2'($urandom), ($urandom_range(0, 7) == 0), r);
        end
        idle(20, 1);

        // Reset while a commit is pending.
        for (int i = 0; i < 16; i++) step(1, 2'd0, 7'($urandom), 2'($urandom), 0, r);
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        idle(1, 1);
        step(1, 2'd0, 7'd3, 2'd2, 0, r);
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        check_val("rstp.pending", MAP_W'(pending), MAP_W'(1));
        do_reset();
        // Both buffers must read 0: commit the (cleared) shadow and look.
        step(1, 2'd1, 7'd0, 2'd0, 0, r);
        idle(1, 1);
        check_val("rstp.shadow_zero", map, '0);

        // frame_count wrap after 256 pulses from zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            idle(1, 1);
            idle(1, 0);
        end
        check_val("wrap.frame_count", MAP_W'(frame_count), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
